// File: rtl/main_memory_responder_if.sv
`default_nettype none
// =============================================================================
// Module   : main_memory_responder_if
// Brief    : Cache-to-memory line request handshake (read/write/address/ready).
// Revision : 1.0 - initial release
// =============================================================================
interface main_memory_responder_if #(
    parameter int ADDR_W = 32
);
    logic              read_mem;
    logic              write_mem;
    logic [ADDR_W-1:0] addr_mem;
    logic              ready_mem;

    modport master (output read_mem, write_mem, addr_mem, input ready_mem);
    modport slave  (input read_mem, write_mem, addr_mem, output ready_mem);
endinterface
`default_nettype wire

// File: rtl/main_memory_responder.sv
`default_nettype none
// =============================================================================
// Module   : main_memory_responder
// Brief    : Fixed-latency main-memory model serving 4-word line read/write bursts.
// Revision : 1.0 - initial release
// =============================================================================
module main_memory_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    main_memory_responder_if.slave bus,
    inout  wire [DATA_W-1:0]       data_mem
);

    localparam int c_idx_w  = $clog2(DEPTH_WORDS);
    localparam int c_line_w = c_idx_w - 2;
    localparam int c_cnt_w  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_lat_load = c_cnt_w'(LATENCY);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAT    = 2'd1,
        S_RBURST = 2'd2,
        S_WBURST = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_next;
    logic [c_line_w-1:0] r_base, w_base_next;
    logic [1:0]          r_beat, w_beat_next;
    logic                r_is_write, w_is_write_next;
    logic                r_ready, w_ready_next;
    logic                w_mem_we;
    logic [c_idx_w-1:0]  w_idx;
    logic                w_unused_addr;

    // Storage deliberately has no reset: contents persist across resets.
    logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

    assign w_idx         = {r_base, r_beat};
    assign bus.ready_mem = r_ready;
    assign data_mem      = (r_state == S_RBURST) ? r_mem[w_idx] : {DATA_W{1'bz}};
    assign w_unused_addr = ^{bus.addr_mem[3:0], bus.addr_mem[ADDR_W-1:c_idx_w+2]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_base     <= '0;
            r_beat     <= '0;
            r_is_write <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_base     <= w_base_next;
            r_beat     <= w_beat_next;
            r_is_write <= w_is_write_next;
            r_ready    <= w_ready_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= data_mem;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_base_next     = r_base;
        w_beat_next     = r_beat;
        w_is_write_next = r_is_write;
        w_ready_next    = r_ready;
        w_mem_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready_next = 1'b1;
                // Write wins a simultaneous request; the held read follows later.
                if (bus.write_mem || bus.read_mem) begin
                    w_base_next     = bus.addr_mem[c_idx_w+1:4];
                    w_is_write_next = bus.write_mem;
                    w_beat_next     = 2'd0;
                    w_cnt_next      = c_lat_load;
                    if (LATENCY == 0) begin
                        w_state_next = bus.write_mem ? S_WBURST : S_RBURST;
                    end else begin
                        w_state_next = S_LAT;
                        w_ready_next = 1'b0;
                    end
                end
            end
            S_LAT: begin
                w_cnt_next = r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    w_state_next = r_is_write ? S_WBURST : S_RBURST;
                    w_ready_next = 1'b1;
                end
            end
            S_RBURST, S_WBURST: begin
                w_mem_we    = (r_state == S_WBURST);
                w_beat_next = r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// =============================================================================
// Module   : tb_main_memory_responder
// Brief    : Scoreboard bench for a LATENCY=20 and a LATENCY=0 memory responder.
// Revision : 1.0 - initial release
// =============================================================================
module tb_main_memory_responder;

    logic        clk;
    logic        rst_n;
    logic        rd      [2];
    logic        wr      [2];
    logic [31:0] addr    [2];
    logic        drv_en  [2];
    logic [31:0] drv_val [2];
    wire  [31:0] dbus0;
    wire  [31:0] dbus1;

    int          checks;
    int          failures;
    logic [31:0] model [2][1024];
    logic [31:0] exp_q [$];

    main_memory_responder_if #(.ADDR_W(32)) ifc0 ();
    main_memory_responder_if #(.ADDR_W(32)) ifc1 ();

    assign ifc0.read_mem  = rd[0];
    assign ifc0.write_mem = wr[0];
    assign ifc0.addr_mem  = addr[0];
    assign ifc1.read_mem  = rd[1];
    assign ifc1.write_mem = wr[1];
    assign ifc1.addr_mem  = addr[1];
    // The bench drives a known value whenever the responder must stay off the bus,
    // so any stray drive from the responder corrupts the observed value.
    assign dbus0 = drv_en[0] ? drv_val[0] : 32'hzzzz_zzzz;
    assign dbus1 = drv_en[1] ? drv_val[1] : 32'hzzzz_zzzz;

    main_memory_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(20)
    ) u_dut_lat20 (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (ifc0.slave),
        .data_mem (dbus0)
    );

    main_memory_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(0)
    ) u_dut_lat0 (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (ifc1.slave),
        .data_mem (dbus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ready_of(input int inst);
        return (inst == 0) ? ifc0.ready_mem : ifc1.ready_mem;
    endfunction

    function automatic logic [31:0] bus_of(input int inst);
        return (inst == 0) ? dbus0 : dbus1;
    endfunction

    function automatic int line_base(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF) & ~3;
    endfunction

    // Issues one request starting just after a negedge; accept happens at the next posedge.
    task automatic do_txn(input int inst, input int lat, input bit wr_op, input bit rd_req,
                          input logic [31:0] a, input logic [3:0][31:0] wd,
                          input bit hold_rd, input bit chk);
        int          base;
        logic [31:0] exp;
        bit          beat;
        base          = line_base(a);
        rd[inst]      = rd_req;
        wr[inst]      = wr_op;
        addr[inst]    = a;
        drv_en[inst]  = 1'b1;
        drv_val[inst] = 32'h0;
        #1;
        check_eq("ready_pre_accept", 32'(ready_of(inst)), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (wr_op) model[inst][base + k] = wd[k];
            else       exp_q.push_back(model[inst][base + k]);
        end
        @(posedge clk);
        for (int t = 0; t <= lat + 4; t++) begin
            @(negedge clk);
            if (t == 0) begin
                wr[inst] = 1'b0;
                if (!hold_rd) rd[inst] = 1'b0;
            end
            beat = (t >= lat) && (t < lat + 4);
            if (!wr_op && beat) begin
                drv_en[inst] = 1'b0;
            end else begin
                drv_en[inst]  = 1'b1;
                drv_val[inst] = (wr_op && beat) ? wd[t - lat] : 32'h0;
            end
            #1;
            check_eq("ready", 32'(ready_of(inst)), (t < lat) ? 32'd0 : 32'd1);
            if (!wr_op && beat) begin
                exp = exp_q.pop_front();
                if (chk) check_eq("rdata", bus_of(inst), exp);
            end else begin
                check_eq("bus_free", bus_of(inst), drv_val[inst]);
            end
        end
    endtask

    localparam logic [3:0][31:0] c_line_a = {32'h3333, 32'h2222, 32'h1111, 32'h0000};
    localparam logic [3:0][31:0] c_line_b = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
    localparam logic [3:0][31:0] c_line_c = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};

    initial begin
        logic [31:0] exp;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'h0;
            drv_en[i] = 1'b1; drv_val[i] = 32'h0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        rd[0] = 1'b1;
        addr[0] = 32'h0000_0090;

        repeat (2) begin
            @(negedge clk); #1;
            check_eq("rst_ready", 32'(ifc0.ready_mem), 32'd1);
            check_eq("rst_bus_free", dbus0, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Storage is uninitialised, so only the handshake of this first read is checked.
        do_txn(0, 20, 1'b0, 1'b1, 32'h0000_0090, '0, 1'b0, 1'b0);

        do_txn(0, 20, 1'b1, 1'b0, 32'h0000_0090, c_line_a, 1'b0, 1'b1);
        do_txn(0, 20, 1'b0, 1'b1, 32'h0000_0094, '0, 1'b0, 1'b1);
        do_txn(0, 20, 1'b0, 1'b1, 32'hC000_0090, '0, 1'b0, 1'b1);

        do_txn(0, 20, 1'b1, 1'b1, 32'hC000_0FF0, c_line_b, 1'b1, 1'b1);
        do_txn(0, 20, 1'b0, 1'b1, 32'hC000_0FF0, '0, 1'b0, 1'b1);

        // Reset ten cycles into a read.
        rd[0] = 1'b1; addr[0] = 32'h0000_0090;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            rd[0] = 1'b0;
        end
        #1 check_eq("lat_ready_low", 32'(ifc0.ready_mem), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_lat_ready", 32'(ifc0.ready_mem), 32'd1);
        check_eq("rst_lat_bus_free", dbus0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 20, 1'b0, 1'b1, 32'h0000_0090, '0, 1'b0, 1'b1);

        // Reset in the middle of a read burst must release the bus at once.
        rd[0] = 1'b1; addr[0] = 32'h0000_0090;
        for (int k = 0; k < 4; k++) exp_q.push_back(model[0][line_base(32'h90) + k]);
        @(posedge clk);
        for (int t = 0; t <= 21; t++) begin
            @(negedge clk);
            rd[0] = 1'b0;
            if (t >= 20) drv_en[0] = 1'b0;
        end
        #1;
        exp = exp_q.pop_front();
        exp = exp_q.pop_front();
        check_eq("burst_beat1", dbus0, exp);
        #1 rst_n = 1'b0;
        drv_en[0] = 1'b1; drv_val[0] = 32'h0;
        #1;
        check_eq("rst_burst_bus_free", dbus0, 32'h0);
        check_eq("rst_burst_ready", 32'(ifc0.ready_mem), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 20, 1'b0, 1'b1, 32'h0000_0090, '0, 1'b0, 1'b1);

        // Zero-latency instance: back-to-back write then read, read accepted at E5.
        do_txn(1, 0, 1'b1, 1'b0, 32'h0000_0200, c_line_c, 1'b0, 1'b1);
        do_txn(1, 0, 1'b0, 1'b1, 32'h0000_0204, '0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
